// File: rtl/lock_supervisor.sv
// Front-end controller for the button combination lock: conditions two raw buttons into press
// pulses, judges attempts from the lock's unlock level, and handles open time and lockout.
module lock_supervisor #(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned OPEN_CYCLES    = 16,
    parameter int unsigned LOCKOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       btn0_raw_i,
    input  logic       btn1_raw_i,
    input  logic       lock_out_i,
    output logic       press0_o,
    output logic       press1_o,
    output logic       lock_rst_o,
    output logic       unlocked_o,
    output logic       alarm_o,
    output logic [1:0] fail_cnt_o,
    output logic [3:0] disp_code_o
);

    localparam int unsigned DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned PW   = $clog2(CODE_LEN + 1);
    localparam int unsigned TMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMax + 1);

    typedef enum logic [2:0] {StReady, StCheck, StOpen, StLockout, StClear} state_e;

    logic [1:0]    sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, req;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];

    state_e        state_q, state_d;
    logic [PW-1:0] press_cnt_q, press_cnt_d;
    logic [1:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          chk_q, chk_d;
    logic          press0_q, press1_q, issue0, issue1;
    logic [3:0]    disp_q, disp_d;

    // Level flips only after DEB_CYCLES consecutive cycles of disagreement.
    always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < 2; b++) begin
            dcnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (dcnt_q[b] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    dcnt_d[b] = dcnt_q[b] + DW'(1);
                end
            end
        end
    end

    assign req    = deb_q & ~deb_dly_q;
    assign issue0 = (state_q == StReady) && req[0] && !req[1];
    assign issue1 = (state_q == StReady) && req[1] && !req[0];

    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        chk_d       = chk_q;
        unique case (state_q)
            StReady: begin
                if (lock_out_i) begin
                    state_d     = StOpen;
                    press_cnt_d = '0;
                    fail_d      = '0;
                    timer_d     = TW'(OPEN_CYCLES);
                end else if (issue0 || issue1) begin
                    press_cnt_d = press_cnt_q + PW'(1);
                    if (press_cnt_d == PW'(CODE_LEN)) begin
                        state_d = StCheck;
                        chk_d   = 1'b0;
                    end
                end
            end
            StCheck: begin
                if (lock_out_i) begin
                    state_d     = StOpen;
                    press_cnt_d = '0;
                    fail_d      = '0;
                    timer_d     = TW'(OPEN_CYCLES);
                end else if (!chk_q) begin
                    chk_d = 1'b1;
                end else if ((32'(fail_q) + 32'd1) == MAX_FAILS) begin
                    state_d = StLockout;
                    timer_d = TW'(LOCKOUT_CYCLES);
                end else begin
                    fail_d  = fail_q + 2'd1;
                    state_d = StClear;
                end
            end
            StOpen: begin
                if (timer_q <= TW'(1)) begin
                    state_d = StClear;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StLockout: begin
                if (timer_q <= TW'(1)) begin
                    fail_d  = '0;
                    state_d = StClear;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StClear: begin
                press_cnt_d = '0;
                state_d     = StReady;
            end
            default: state_d = StReady;
        endcase
    end

    // Display tracks the state being entered so it changes on the same edge.
    always_comb begin
        disp_d = 4'h0;
        case (state_d)
            StReady, StCheck: disp_d = 4'(press_cnt_d);
            StOpen:           disp_d = 4'hA;
            StLockout:        disp_d = 4'hE;
            default:          disp_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_dly_q   <= '0;
            for (int b = 0; b < 2; b++) dcnt_q[b] <= '0;
            state_q     <= StReady;
            press_cnt_q <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            chk_q       <= 1'b0;
            press0_q    <= 1'b0;
            press1_q    <= 1'b0;
            disp_q      <= 4'h0;
        end else begin
            sync1_q     <= {btn1_raw_i, btn0_raw_i};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            for (int b = 0; b < 2; b++) dcnt_q[b] <= dcnt_d[b];
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            chk_q       <= chk_d;
            press0_q    <= issue0;
            press1_q    <= issue1;
            disp_q      <= disp_d;
        end
    end

    assign press0_o    = press0_q;
    assign press1_o    = press1_q;
    assign unlocked_o  = (state_q == StOpen);
    assign alarm_o     = (state_q == StLockout);
    assign lock_rst_o  = (state_q == StLockout) || (state_q == StClear);
    assign fail_cnt_o  = fail_q;
    assign disp_code_o = disp_q;

endmodule
